// File: rtl/motoro3_pkg.sv
// Shared types and helpers for the motoro3 six-step commutation stage.
package motoro3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    PH_A,
    PH_B,
    PH_C
  } phase_e;

  typedef struct packed {
    phase_e hi;
    phase_e lo;
  } comm_t;

  localparam logic [2:0] STEP_MAX = 3'd5;

  // Commutation table: step -> driven high-side phase / driven low-side phase
  function automatic comm_t comm_lookup(input logic [2:0] step);
    comm_t c;
    case (step)
      3'd0:    c = '{hi: PH_A, lo: PH_B};
      3'd1:    c = '{hi: PH_A, lo: PH_C};
      3'd2:    c = '{hi: PH_B, lo: PH_C};
      3'd3:    c = '{hi: PH_B, lo: PH_A};
      3'd4:    c = '{hi: PH_C, lo: PH_A};
      3'd5:    c = '{hi: PH_C, lo: PH_B};
      default: c = '{hi: PH_A, lo: PH_B};
    endcase
    return c;
  endfunction

  // Next commutation step with wrap in either direction
  function automatic logic [2:0] step_next(input logic [2:0] s, input logic rev);
    if (rev) begin
      return (s == 3'd0) ? STEP_MAX : s - 3'd1;
    end
    return (s >= STEP_MAX) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/motoro3_deadtime_edge.sv
// Per-edge dead-time qualifier for the PWM-driven gates. ecnt measures how
// long pwmS has been stable; a turn-on is only allowed once it reaches dtEff.
module motoro3_deadtime_edge
  import motoro3_pkg::*;
#(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pwmNext_i,
  input  logic            pwmS_i,
  input  logic [DT_W-1:0] dtEff_i,
  input  logic            clear_i,
  output logic            hsOk_o,
  output logic            lsOk_o
);

  logic [DT_W-1:0] ecnt_q, ecnt_d;
  logic            primed_q, primed_d;
  logic            pwmEdge;
  logic            ok;

  assign pwmEdge = pwmNext_i ^ pwmS_i;

  // The DEAD interval before RUN already holds every gate off for dtEff
  // cycles, so the first PWM level after entry is released at once (primed);
  // from the first pwmS change onward the ecnt dead-time gates each turn-on.
  assign ok     = clear_i | primed_q | (ecnt_q >= dtEff_i);
  assign hsOk_o = pwmS_i & ok;
  assign lsOk_o = ~pwmS_i & ok;

  // Stability counter and primed flag next-state
  always_comb begin
    ecnt_d   = ecnt_q;
    primed_d = primed_q;
    if (pwmEdge || clear_i) begin
      ecnt_d = '0;
    end else if (ecnt_q != '1) begin
      ecnt_d = ecnt_q + 1'b1;
    end
    if (pwmEdge) begin
      primed_d = 1'b0;
    end else if (clear_i) begin
      primed_d = 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ecnt_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      ecnt_q   <= ecnt_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/motoro3_phase_driver.sv
// Six-step commutation FSM, step register and registered gate-drive mux.
module motoro3_phase_driver
  import motoro3_pkg::*;
#(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pwm,
  input  logic            m3cntLast1,
  input  logic            m3r_enable,
  input  logic            m3r_dirRev,
  input  logic            m3r_syncRect,
  input  logic [DT_W-1:0] m3r_deadTime,
  output logic            gAH,
  output logic            gAL,
  output logic            gBH,
  output logic            gBL,
  output logic            gCH,
  output logic            gCL,
  output logic [2:0]      stepIdx,
  output logic            running
);

  localparam logic [DT_W-1:0] ONE = {{(DT_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [2:0]      stepIdx_q, stepIdx_d;
  logic [DT_W-1:0] dcnt_q, dcnt_d;
  logic [DT_W-1:0] dtLat_q, dtLat_d;
  logic [DT_W-1:0] dtEff;
  logic            pwmS_q;
  logic [2:0]      hs_q, hs_d, ls_q, ls_d;
  logic            enterRun;
  logic            hsOk, lsOk;
  comm_t           comm;

  assign dtEff = (dtLat_q == '0) ? ONE : dtLat_q;

  motoro3_deadtime_edge #(.DT_W(DT_W)) u_edge (
    .clk_i     (clk),
    .rst_i     (rst),
    .pwmNext_i (pwm),
    .pwmS_i    (pwmS_q),
    .dtEff_i   (dtEff),
    .clear_i   (enterRun),
    .hsOk_o    (hsOk),
    .lsOk_o    (lsOk)
  );

  // FSM next-state: disable has priority, then step sanity, then strobes
  always_comb begin
    state_d   = state_q;
    stepIdx_d = stepIdx_q;
    dcnt_d    = dcnt_q;
    dtLat_d   = dtLat_q;
    if (!m3r_enable) begin
      state_d = ST_IDLE;
      dcnt_d  = '0;
    end else if (stepIdx_q > STEP_MAX) begin
      stepIdx_d = 3'd0;
      state_d   = ST_DEAD;
      dcnt_d    = ONE;
      dtLat_d   = m3r_deadTime;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DEAD;
          dcnt_d  = ONE;
          dtLat_d = m3r_deadTime;
        end
        ST_DEAD: begin
          if (m3cntLast1) begin
            stepIdx_d = step_next(stepIdx_q, m3r_dirRev);
            dcnt_d    = ONE;
            dtLat_d   = m3r_deadTime;
          end else if (dcnt_q == dtEff) begin
            state_d = ST_RUN;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (m3cntLast1) begin
            stepIdx_d = step_next(stepIdx_q, m3r_dirRev);
            state_d   = ST_DEAD;
            dcnt_d    = ONE;
            dtLat_d   = m3r_deadTime;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end
      endcase
    end
    enterRun = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // Gate mux: evaluated against the next state so gates drop on the same
  // edge the FSM leaves RUN
  always_comb begin
    hs_d = '0;
    ls_d = '0;
    comm = comm_lookup(stepIdx_d);
    if (state_d == ST_RUN) begin
      hs_d[comm.hi] = hsOk;
      ls_d[comm.lo] = 1'b1;
      if (m3r_syncRect) begin
        ls_d[comm.hi] = lsOk;
      end
    end
  end

  // State, step, counters, PWM sync flop and gate output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stepIdx_q <= 3'd0;
      dcnt_q    <= '0;
      dtLat_q   <= '0;
      pwmS_q    <= 1'b0;
      hs_q      <= '0;
      ls_q      <= '0;
    end else begin
      state_q   <= state_d;
      stepIdx_q <= stepIdx_d;
      dcnt_q    <= dcnt_d;
      dtLat_q   <= dtLat_d;
      pwmS_q    <= pwm;
      hs_q      <= hs_d;
      ls_q      <= ls_d;
    end
  end

  assign gAH     = hs_q[PH_A];
  assign gAL     = ls_q[PH_A];
  assign gBH     = hs_q[PH_B];
  assign gBL     = ls_q[PH_B];
  assign gCH     = hs_q[PH_C];
  assign gCL     = ls_q[PH_C];
  assign stepIdx = stepIdx_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_motoro3_phase_driver.sv
// Scoreboard bench for motoro3_phase_driver: stimulus pushes the expected
// output word for a given cycle; the negedge monitor pops and compares.
module tb_motoro3_phase_driver;

  logic       clk = 1'b0;
  logic       rst, pwm, strobe, en, rev, sr;
  logic [7:0] dt;
  logic       gAH, gAL, gBH, gBL, gCH, gCL, running;
  logic [2:0] stepIdx;

  motoro3_phase_driver #(.DT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm          (pwm),
    .m3cntLast1   (strobe),
    .m3r_enable   (en),
    .m3r_dirRev   (rev),
    .m3r_syncRect (sr),
    .m3r_deadTime (dt),
    .gAH          (gAH),
    .gAL          (gAL),
    .gBH          (gBH),
    .gBL          (gBL),
    .gCH          (gCH),
    .gCL          (gCL),
    .stepIdx      (stepIdx),
    .running      (running)
  );

  always #5 clk = ~clk;

  // Gate order {AH,AL,BH,BL,CH,CL}; pwm held high, no sync rectification
  localparam logic [5:0] TBL [0:5] = '{6'b100100, 6'b100001, 6'b001001,
                                       6'b011000, 6'b010010, 6'b000110};
  localparam logic [5:0] G0      = 6'b000000;
  localparam logic [5:0] SR_HI   = 6'b100100;
  localparam logic [5:0] SR_LO   = 6'b010100;
  localparam logic [5:0] SR_NONE = 6'b000100;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t e;
  logic [9:0] obs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input logic [5:0] g, input logic [2:0] s,
                           input logic r, input string nm);
    exp_t x;
    x.cyc = cyc + off;
    x.vec = {g, s, r};
    x.nm  = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare every scheduled expectation, plus shoot-through each cycle
  always @(negedge clk) begin
    obs = {gAH, gAL, gBH, gBL, gCH, gCL, stepIdx, running};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
      end else if (obs !== e.vec) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got gates=%b step=%0d run=%b, want gates=%b step=%0d run=%b",
                 e.nm, cyc, obs[9:4], obs[3:1], obs[0], e.vec[9:4], e.vec[3:1], e.vec[0]);
      end
    end
    n_cmp++;
    if ((gAH && gAL) || (gBH && gBL) || (gCH && gCL)) begin
      n_fail++;
      $display("FAIL shoot_through @cyc %0d: gates=%b, want no phase with H and L both 1",
               cyc, obs[9:4]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want stimulus to complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pwm = 1'b0; strobe = 1'b0; en = 1'b0; rev = 1'b0; sr = 1'b0; dt = 8'd4;
    tick(3);
    expect_at(0, G0, 3'd0, 1'b0, "reset_state");
    rst = 1'b0;
    pwm = 1'b1;
    tick(2);

    // Enable: 4 cycles of DEAD, then step 0 with pwm high
    en = 1'b1;
    for (int k = 1; k <= 4; k++) expect_at(k, G0, 3'd0, 1'b0, "enable_dead");
    expect_at(5, TBL[0], 3'd0, 1'b1, "enable_run");
    expect_at(8, TBL[0], 3'd0, 1'b1, "enable_hold");
    tick(20);

    // Forward: seven strobes 50 cycles apart
    for (int i = 0; i < 7; i++) begin
      logic [2:0] s;
      s = 3'((i + 1) % 6);
      strobe = 1'b1;
      expect_at(1,  G0,     s, 1'b0, "fwd_blank_first");
      expect_at(4,  G0,     s, 1'b0, "fwd_blank_last");
      expect_at(5,  TBL[s], s, 1'b1, "fwd_table");
      expect_at(30, TBL[s], s, 1'b1, "fwd_table_hold");
      tick(1);
      strobe = 1'b0;
      tick(49);
    end

    // Reverse: 1 -> 0 -> 5
    rev = 1'b1;
    strobe = 1'b1;
    expect_at(1, G0,     3'd0, 1'b0, "rev_blank0");
    expect_at(5, TBL[0], 3'd0, 1'b1, "rev_table0");
    tick(1); strobe = 1'b0; tick(29);
    strobe = 1'b1;
    expect_at(1,  G0,     3'd5, 1'b0, "rev_wrap_blank");
    expect_at(5,  TBL[5], 3'd5, 1'b1, "rev_wrap_table");
    expect_at(20, TBL[5], 3'd5, 1'b1, "rev_wrap_hold");
    tick(1); strobe = 1'b0; tick(29);

    // Back-to-back strobes 2 cycles apart keep the gates off
    for (int j = 0; j < 4; j++) begin
      logic [2:0] s;
      s = 3'(4 - j);
      strobe = 1'b1;
      expect_at(1, G0, s, 1'b0, "b2b_off_a");
      expect_at(2, G0, s, 1'b0, "b2b_off_b");
      tick(1); strobe = 1'b0; tick(1);
    end
    expect_at(3, TBL[1], 3'd1, 1'b1, "b2b_resume");
    tick(20);

    // Sync rectification on step 0 with dead-time 3
    dt = 8'd3; sr = 1'b1;
    strobe = 1'b1;
    expect_at(1, G0,    3'd0, 1'b0, "sr_blank_first");
    expect_at(3, G0,    3'd0, 1'b0, "sr_blank_last");
    expect_at(4, SR_HI, 3'd0, 1'b1, "sr_entry");
    tick(1); strobe = 1'b0; tick(9);
    for (int t = 0; t < 4; t++) begin
      logic [5:0] oldp, newp;
      oldp = pwm ? SR_HI : SR_LO;
      pwm  = ~pwm;
      newp = pwm ? SR_HI : SR_LO;
      expect_at(1, oldp,    3'd0, 1'b1, "sr_sync_delay");
      expect_at(2, SR_NONE, 3'd0, 1'b1, "sr_turnoff");
      expect_at(4, SR_NONE, 3'd0, 1'b1, "sr_deadtime");
      expect_at(5, newp,    3'd0, 1'b1, "sr_turnon");
      tick(10);
    end

    // Dead-time 0 behaves as a 1-cycle blank
    sr = 1'b0; rev = 1'b0; dt = 8'd0; pwm = 1'b1;
    tick(2);
    strobe = 1'b1;
    expect_at(1, G0,     3'd1, 1'b0, "dt0_blank");
    expect_at(2, TBL[1], 3'd1, 1'b1, "dt0_table");
    tick(1); strobe = 1'b0; tick(9);

    // Disable coinciding with a strobe: disable wins, no step advance
    en = 1'b0; strobe = 1'b1;
    expect_at(1, G0, 3'd1, 1'b0, "disable_wins");
    tick(1); strobe = 1'b0; tick(2);

    // Strobe while idle is ignored
    strobe = 1'b1;
    expect_at(1, G0, 3'd1, 1'b0, "idle_strobe");
    expect_at(3, G0, 3'd1, 1'b0, "idle_strobe_hold");
    tick(1); strobe = 1'b0; tick(4);

    // Reset while gAH is driven
    en = 1'b1;
    expect_at(1, G0,     3'd1, 1'b0, "reen_dead");
    expect_at(2, TBL[1], 3'd1, 1'b1, "reen_run");
    tick(3);
    rst = 1'b1;
    expect_at(0, TBL[1], 3'd1, 1'b1, "pre_reset");
    expect_at(1, G0,     3'd0, 1'b0, "mid_reset");
    tick(1);
    en = 1'b0; rst = 1'b0;
    tick(4);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
